alu_serial: RTL and testbench
=============================

ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, minimum 2.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only while ready=1.
REQ-005 a  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 b  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 cin  input  1  carry-in; captured on the accepting edge.
REQ-008 ALUop  input  2  operation select: 00 AND, 01 OR, 10 ADD, 11 XOR; captured on the accepting edge.
REQ-009 ready  output  1  high when idle and able to accept start.
REQ-010 busy  output  1  high while bits are being processed.
REQ-011 done  output  1  one-cycle pulse; result, cout and zero are valid.
REQ-012 result  output  WIDTH  operation result.
REQ-013 cout  output  1  carry out of the MSB for ADD; 0 for AND, OR and XOR.
REQ-014 zero  output  1  high when result equals 0.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE to RUN on start=1.
- RUN to DONE after WIDTH bit cycles.
- DONE to IDLE unconditionally after one cycle.
REQ-016 ready=1 only in IDLE; busy=1 only in RUN; done=1 only in DONE.
REQ-017 The accepting edge (IDLE, start=1) SHALL perform all of:
- latch a, b and ALUop;
- load the carry register with cin;
- clear the bit counter to 0.
REQ-018 Each RUN cycle SHALL process one bit, LSB first:
- present bit[counter] of the latched a and b, the carry register, and the latched ALUop to the 1-bit slice;
- shift the slice result into the MSB of the result shift register (shift right);
- load the carry register with the slice carry-out;
- increment the counter.
REQ-019 RUN SHALL exit on the edge where counter equals WIDTH-1; after that edge result[0] holds bit 0 and result[WIDTH-1] holds the MSB.
REQ-020 Latency: done SHALL be high in the cycle that follows exactly WIDTH+1 rising edges after the accepting edge, counting the edge that moves RUN to DONE.
REQ-021 ADD is modulo 2^WIDTH. cout SHALL equal the final carry register value when ALUop=10, and 0 otherwise.
REQ-022 For AND, OR and XOR, cin SHALL have no effect on result.
REQ-023 result, cout and zero SHALL be registered and SHALL hold their values from DONE until the next accepting edge.
REQ-024 start while busy or in DONE SHALL be ignored; operand changes during RUN SHALL have no effect.
REQ-025 start held high continuously SHALL start a new operation on the first IDLE cycle after each DONE.

Reset
REQ-026 On reset=1 at a rising edge, from any state including mid-RUN, the block SHALL:
- enter IDLE;
- set ready=1, busy=0 and done=0;
- set result=0, cout=0 and zero=1;
- clear the counter and the carry register.
REQ-027 An operation aborted by reset SHALL produce no done pulse.
REQ-028 reset SHALL take priority over start on the same edge.

Structure
REQ-029 A shared package SHALL hold:
- the ALUop encodings (OP_AND, OP_OR, OP_ADD, OP_XOR);
- the FSM state type.
REQ-030 The bit-slice datapath SHALL be one instance of the existing 1-bit ALU slice alu1Bit (ports result, cout, ALUop, a, b, cin), with no duplicated slice logic.
REQ-031 The counter width SHALL be $clog2(WIDTH).

Verification
REQ-032 ADD, a=8'hFF, b=8'h01, cin=0 -> result=8'h00, cout=1, zero=1; done high exactly 9 edges after acceptance.
REQ-033 AND, a=8'hF0, b=8'h3C, cin=1 -> result=8'h30, cout=0, zero=0.
REQ-034 XOR, a=8'hAA, b=8'h55 -> result=8'hFF, cout=0; OR with the same operands -> 8'hFF.
REQ-035 ADD, a=8'h7F, b=8'h00, cin=1 -> result=8'h80, cout=0.
- During this run, pulse start with a=8'h01, b=8'h01, ALUop=00 on the third RUN cycle.
- Required: that request is ignored and the result is unchanged.
REQ-036 Reset asserted on the 4th RUN cycle of an ADD -> next cycle ready=1, busy=0, result=0, zero=1, and no done follows.
- A subsequent ADD 8'h12+8'h34 -> result=8'h46.

Source files
------------

// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU: operation encodings and FSM state type.
// No logic; constants and types only.
// Imported by the slice and the top.
package alu_serial_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_serial_slice.sv
// 1-bit ALU slice (alu1Bit): AND / OR / full-add / XOR on a single bit.
// Latency: purely combinational.
// Backpressure: none; cout is the add carry for ADD and 0 for every other op.
module alu1Bit
    import alu_serial_pkg::*;
(
    output logic       result,
    output logic       cout,
    input  logic [1:0] ALUop,
    input  logic       a,
    input  logic       b,
    input  logic       cin
);

    // Select the bit operation; only ADD consumes or produces a carry.
    always_comb begin
        result = 1'b0;
        cout   = 1'b0;
        case (ALUop)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: begin
                result = a ^ b ^ cin;
                cout   = (a & b) | (cin & (a ^ b));
            end
            default: result = a ^ b;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU: processes one operand bit per cycle, LSB first, through one alu1Bit slice.
// Latency: done pulses WIDTH+1 edges after the accepting edge (accept, then WIDTH RUN edges).
// Backpressure: start is only honoured while ready=1; requests in RUN or DONE are dropped.
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       ALUop,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;

    logic               slice_res;
    logic               slice_cout;
    logic [WIDTH-1:0]   res_shift;
    logic               last_bit;

    alu1Bit u_slice (
        .result (slice_res),
        .cout   (slice_cout),
        .ALUop  (op_q),
        .a      (a_q[cnt_q]),
        .b      (b_q[cnt_q]),
        .cin    (carry_q)
    );

    assign res_shift = {slice_res, res_q[WIDTH-1:1]};
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and datapath update; every register holds unless its state says otherwise.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    op_d    = ALUop;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                res_d   = res_shift;
                carry_d = slice_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d = DONE;
                    // Flags settle with the final shift so they are valid alongside done.
                    cout_d  = (op_q == OP_ADD) ? slice_cout : 1'b0;
                    zero_d  = (res_shift == '0);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset that abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = res_q;
    assign cout   = cout_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_serial.sv
module tb_alu_serial;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [1:0] ALUop;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout;
    logic       zero;

    int checks   = 0;
    int failures = 0;

    alu_serial #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .ALUop  (ALUop),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request at a falling edge, let the next rising edge accept it,
    // and return at the following falling edge with start released.
    task automatic start_op(input logic [1:0] op, input logic [7:0] av,
                            input logic [7:0] bv, input logic ci);
        @(negedge clk);
        ALUop = op; a = av; b = bv; cin = ci; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count rising edges since the accepting edge (which counts as 1) until done.
    task automatic wait_done(output int edges, output bit seen);
        edges = 1;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; ALUop = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ready, busy, done} !== 3'b100) begin
            failures++;
            $display("FAIL reset_flags got rdy/busy/done=%b exp 100", {ready, busy, done});
        end
        checks++;
        if ({result, cout, zero} !== {8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_outputs got result=%h cout=%b zero=%b exp 00 0 1", result, cout, zero);
        end
        // reset wins over a simultaneous start
        start = 1'b1; ALUop = 2'b10; a = 8'h11; b = 8'h22;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ready, busy} !== 2'b10) begin
            failures++;
            $display("FAIL reset_priority got rdy/busy=%b exp 10", {ready, busy});
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_add();
        int  edges;
        bit  seen;
        start_op(2'b10, 8'hFF, 8'h01, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL add_busy got %b exp 1", busy);
        end
        wait_done(edges, seen);
        checks++;
        if (!seen || edges != 9) begin
            failures++;
            $display("FAIL add_latency got seen=%0d edges=%0d exp 1 9", seen, edges);
        end
        checks++;
        if ({result, cout, zero} !== {8'h00, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL add_ff_01 got %h %b %b exp 00 1 1", result, cout, zero);
        end
        start_op(2'b10, 8'h0F, 8'h01, 1'b1);
        wait_done(edges, seen);
        checks++;
        if (!seen || {result, cout, zero} !== {8'h11, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL add_cin got seen=%0d %h %b %b exp 1 11 0 0", seen, result, cout, zero);
        end
    endtask

    task automatic test_logic();
        int edges;
        bit seen;
        start_op(2'b00, 8'hF0, 8'h3C, 1'b1);
        wait_done(edges, seen);
        checks++;
        if (!seen || {result, cout, zero} !== {8'h30, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL and_op got seen=%0d %h %b %b exp 1 30 0 0", seen, result, cout, zero);
        end
        start_op(2'b11, 8'hAA, 8'h55, 1'b0);
        wait_done(edges, seen);
        checks++;
        if (!seen || {result, cout, zero} !== {8'hFF, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL xor_op got seen=%0d %h %b %b exp 1 ff 0 0", seen, result, cout, zero);
        end
        start_op(2'b01, 8'hAA, 8'h55, 1'b1);
        wait_done(edges, seen);
        checks++;
        if (!seen || {result, cout, zero} !== {8'hFF, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL or_op got seen=%0d %h %b %b exp 1 ff 0 0", seen, result, cout, zero);
        end
        start_op(2'b11, 8'hAA, 8'hAA, 1'b1);
        wait_done(edges, seen);
        checks++;
        if (!seen || {result, cout, zero} !== {8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL xor_zero got seen=%0d %h %b %b exp 1 00 0 1", seen, result, cout, zero);
        end
    endtask

    task automatic test_ignored_start();
        int edges;
        bit seen;
        start_op(2'b10, 8'h7F, 8'h00, 1'b1);
        // now in RUN cycle 1; step to RUN cycle 3
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b1; a = 8'h01; b = 8'h01; ALUop = 2'b00;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL ignore_busy got %b exp 1", busy);
        end
        wait_done(edges, seen);
        checks++;
        if (!seen || {result, cout, zero} !== {8'h80, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL ignore_result got seen=%0d %h %b %b exp 1 80 0 0", seen, result, cout, zero);
        end
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if ({ready, result} !== {1'b1, 8'h80}) begin
            failures++;
            $display("FAIL ignore_hold got ready=%b result=%h exp 1 80", ready, result);
        end
    endtask

    task automatic test_reset_abort();
        int edges;
        bit seen;
        int done_cnt;
        start_op(2'b10, 8'hAA, 8'h11, 1'b0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({ready, busy, done} !== 3'b100) begin
            failures++;
            $display("FAIL abort_flags got rdy/busy/done=%b exp 100", {ready, busy, done});
        end
        checks++;
        if ({result, cout, zero} !== {8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL abort_outputs got %h %b %b exp 00 0 1", result, cout, zero);
        end
        done_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (done === 1'b1) done_cnt++;
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (done_cnt != 0) begin
            failures++;
            $display("FAIL abort_no_done got %0d done cycles exp 0", done_cnt);
        end
        start_op(2'b10, 8'h12, 8'h34, 1'b0);
        wait_done(edges, seen);
        checks++;
        if (!seen || {result, cout, zero} !== {8'h46, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL after_abort got seen=%0d %h %b %b exp 1 46 0 0", seen, result, cout, zero);
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        bit seen;
        @(negedge clk);
        ALUop = 2'b10; a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_done(edges, seen);
        checks++;
        if (!seen || result !== 8'h07) begin
            failures++;
            $display("FAIL b2b_first got seen=%0d %h exp 1 07", seen, result);
        end
        ALUop = 2'b11; a = 8'h05; b = 8'h03;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_idle got ready=%b exp 1", ready);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart got busy=%b exp 1", busy);
        end
        wait_done(edges, seen);
        checks++;
        if (!seen || {result, cout, zero} !== {8'h06, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_second got seen=%0d %h %b %b exp 1 06 0 0", seen, result, cout, zero);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic();
        test_ignored_start();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
